// File: rtl/adbg_pkg.sv
// Shared types and constants for the debug burst receiver.
// Holds the receive FSM state encoding and the CRC32 width/initial value.
// The CRC engine itself lives outside this package as a sibling instance.
package adbg_pkg;

    localparam int          CRC_W    = 32;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_START = 3'd1,
        ST_DATA       = 3'd2,
        ST_CRC_RX     = 3'd3,
        ST_CHECK      = 3'd4
    } adbg_state_e;

endpackage

// File: rtl/adbg_burst_rx.sv
// Serial burst receiver: start bit, word_count LSB-first words, optional 32-bit CRC trailer.
// Latency: a word appears on word_o the cycle after its last bit; done_o one cycle after CHECK.
// Backpressure: word_valid_o holds until word_ready_i; an unaccepted word is overwritten and overrun_o sticks.
// Build option: define ADBG_BURST_RX_CRC_EN to receive and check the CRC trailer.
module adbg_burst_rx #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [CW-1:0] word_count_i,
    input  logic          bit_valid_i,
    input  logic          tdi_i,
    output logic [DW-1:0] word_o,
    output logic          word_valid_o,
    input  logic          word_ready_i,
    output logic          crc_clr_o,
    output logic          crc_en_o,
    output logic          crc_data_o,
    input  logic [31:0]   crc_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          crc_match_o,
    output logic          overrun_o
);
    import adbg_pkg::*;

    localparam logic [4:0] LAST_BIT = 5'(DW - 1);

`ifdef ADBG_BURST_RX_CRC_EN
    localparam adbg_state_e AFTER_DATA   = ST_CRC_RX;
    localparam logic [4:0]  LAST_CRC_BIT = 5'(CRC_W - 1);
`else
    localparam adbg_state_e AFTER_DATA   = ST_CHECK;
`endif

    adbg_state_e   state_q;
    logic [4:0]    bit_cnt_q;
    logic [CW-1:0] wcnt_q;
    logic [DW-1:0] sh_q;
    logic [DW-1:0] sh_d;
    logic [DW-1:0] word_q;
    logic          word_valid_q;
    logic          done_q;
    logic          crc_match_q;
    logic          overrun_q;

`ifdef ADBG_BURST_RX_CRC_EN
    logic [CRC_W-1:0] rx_crc_q;
    logic [CRC_W-1:0] rx_crc_d;

    // Trailer bits arrive LSB first, so they enter from the top.
    always_comb rx_crc_d = {tdi_i, rx_crc_q[CRC_W-1:1]};
`endif

    // Data bits arrive LSB first; shifting in from the MSB leaves the first bit in bit 0.
    always_comb sh_d = {tdi_i, sh_q[DW-1:1]};

    // Receive FSM with registered word, status and handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            wcnt_q       <= '0;
            sh_q         <= '0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            done_q       <= 1'b0;
            crc_match_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef ADBG_BURST_RX_CRC_EN
            rx_crc_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (word_valid_q && word_ready_i) begin
                word_valid_q <= 1'b0;
            end
            if (start_i) begin
                // Restart from any state; partial progress is dropped.
                state_q      <= ST_WAIT_START;
                wcnt_q       <= word_count_i;
                bit_cnt_q    <= '0;
                overrun_q    <= 1'b0;
                crc_match_q  <= 1'b0;
                word_valid_q <= 1'b0;
            end else begin
                case (state_q)
                    ST_WAIT_START: begin
                        if (bit_valid_i && tdi_i) begin
                            bit_cnt_q <= '0;
                            state_q   <= (wcnt_q == '0) ? AFTER_DATA : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        if (bit_valid_i) begin
                            sh_q <= sh_d;
                            if (bit_cnt_q == LAST_BIT) begin
                                bit_cnt_q    <= '0;
                                word_q       <= sh_d;
                                word_valid_q <= 1'b1;
                                if (word_valid_q && !word_ready_i) begin
                                    overrun_q <= 1'b1;
                                end
                                wcnt_q <= wcnt_q - CW'(1);
                                if (wcnt_q == CW'(1)) begin
                                    state_q <= AFTER_DATA;
                                end
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
`ifdef ADBG_BURST_RX_CRC_EN
                    ST_CRC_RX: begin
                        if (bit_valid_i) begin
                            rx_crc_q <= rx_crc_d;
                            if (bit_cnt_q == LAST_CRC_BIT) begin
                                bit_cnt_q <= '0;
                                state_q   <= ST_CHECK;
                            end else begin
                                bit_cnt_q <= bit_cnt_q + 5'd1;
                            end
                        end
                    end
`endif
                    ST_CHECK: begin
`ifdef ADBG_BURST_RX_CRC_EN
                        crc_match_q <= (rx_crc_q == crc_i);
`else
                        crc_match_q <= 1'b1;
`endif
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef ADBG_BURST_RX_CRC_EN
    // The CRC engine is cleared on every (re)start and advances only on payload bits.
    assign crc_clr_o  = rst | start_i;
    assign crc_en_o   = (state_q == ST_DATA) && bit_valid_i && !start_i;
    assign crc_data_o = crc_en_o & tdi_i;
`else
    logic unused_crc_i;
    assign unused_crc_i = ^crc_i;
    assign crc_clr_o    = 1'b0;
    assign crc_en_o     = 1'b0;
    assign crc_data_o   = 1'b0;
`endif

    assign word_o       = word_q;
    assign word_valid_o = word_valid_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign crc_match_o  = crc_match_q;
    assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_adbg_burst_rx.sv
// Bench for adbg_burst_rx (DW=8): scoreboard of expected words plus a behavioural CRC32 engine.
// Works in both builds; CRC-specific expectations switch on ADBG_BURST_RX_CRC_EN.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge or mid-cycle.
module tb_adbg_burst_rx;
    import adbg_pkg::*;

    localparam int DW = 8;
    localparam int CW = 16;
`ifdef ADBG_BURST_RX_CRC_EN
    localparam logic CLR_EXP     = 1'b1;
    localparam int   EN_PER_WORD = DW;
`else
    localparam logic CLR_EXP     = 1'b0;
    localparam int   EN_PER_WORD = 0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [CW-1:0] word_count_i;
    logic          bit_valid_i;
    logic          tdi_i;
    logic [DW-1:0] word_o;
    logic          word_valid_o;
    logic          word_ready_i;
    logic          crc_clr_o;
    logic          crc_en_o;
    logic          crc_data_o;
    logic [31:0]   crc_i;
    logic          busy_o;
    logic          done_o;
    logic          crc_match_o;
    logic          overrun_o;

    int n_cmp = 0;
    int n_err = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int vld_cycles = 0;
    logic [DW-1:0] exp_q[$];

    adbg_burst_rx #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .word_count_i(word_count_i),
        .bit_valid_i(bit_valid_i), .tdi_i(tdi_i), .word_o(word_o),
        .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
        .crc_clr_o(crc_clr_o), .crc_en_o(crc_en_o), .crc_data_o(crc_data_o),
        .crc_i(crc_i), .busy_o(busy_o), .done_o(done_o),
        .crc_match_o(crc_match_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;

    // Reflected CRC32, one bit per step.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return (c >> 1) ^ (((c[0] ^ b) == 1'b1) ? 32'hEDB8_8320 : 32'h0);
    endfunction

    function automatic logic [31:0] crc_words(input logic [DW-1:0] w0, input logic [DW-1:0] w1);
        logic [31:0] c;
        c = CRC_INIT;
        for (int i = 0; i < DW; i++) c = crc_step(c, w0[i]);
        for (int i = 0; i < DW; i++) c = crc_step(c, w1[i]);
        return c;
    endfunction

    // Sibling CRC engine model.
    always @(posedge clk) begin
        if (crc_clr_o) crc_i <= CRC_INIT;
        else if (crc_en_o) crc_i <= crc_step(crc_i, crc_data_o);
    end

    // Output monitor: event counters and scoreboard pop on each accepted word.
    always @(negedge clk) begin
        if (crc_en_o) en_cnt++;
        if (done_o) done_cnt++;
        if (word_valid_o) vld_cycles++;
        if (!rst && word_valid_o && word_ready_i) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL word_unexpected: got %h, none expected", word_o);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (word_o !== e) begin
                    n_err++;
                    $display("FAIL word_data: got %h, want %h", word_o, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        if ($urandom_range(0, 3) == 0) begin
            bit_valid_i = 1'b0;
            tdi_i       = 1'($urandom_range(0, 1));
            tick();
        end
        bit_valid_i = 1'b1;
        tdi_i       = b;
        tick();
        bit_valid_i = 1'b0;
        tdi_i       = 1'b0;
    endtask

    task automatic send_word(input logic [DW-1:0] w, input bit expect_it);
        if (expect_it) exp_q.push_back(w);
        for (int i = 0; i < DW; i++) send_bit(w[i]);
    endtask

    task automatic send_crc(input logic [31:0] c);
        for (int i = 0; i < 32; i++) send_bit(c[i]);
    endtask

    task automatic do_start(input logic [CW-1:0] n, input string tag);
        start_i      = 1'b1;
        word_count_i = n;
        #1;
        n_cmp++;
        if (crc_clr_o !== CLR_EXP) begin
            n_err++;
            $display("FAIL %s_crc_clr: got %b, want %b", tag, crc_clr_o, CLR_EXP);
        end
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        en_cnt     = 0;
        done_cnt   = 0;
        vld_cycles = 0;
        n_cmp++;
        if (busy_o !== 1'b1 || overrun_o !== 1'b0 || word_valid_o !== 1'b0 || crc_match_o !== 1'b0) begin
            n_err++;
            $display("FAIL %s_armed: got busy=%b ovr=%b vld=%b match=%b, want 1 0 0 0",
                     tag, busy_o, overrun_o, word_valid_o, crc_match_o);
        end
    endtask

    task automatic wait_done(input logic exp_match, input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done_o === 1'b1) seen = 1'b1;
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s_done_timeout: got no done_o within 40 cycles, want one pulse", tag);
        end else if (crc_match_o !== exp_match) begin
            n_err++;
            $display("FAIL %s_crc_match: got %b, want %b", tag, crc_match_o, exp_match);
        end
        tick();
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || done_cnt != 1) begin
            n_err++;
            $display("FAIL %s_done_pulse: got done=%b busy=%b pulses=%0d, want 0 0 1",
                     tag, done_o, busy_o, done_cnt);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; word_count_i = '0; bit_valid_i = 1'b0;
        tdi_i = 1'b0; word_ready_i = 1'b1;
        tick(); tick();
        n_cmp++;
        if (word_o !== '0 || word_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            crc_match_o !== 1'b0 || overrun_o !== 1'b0 || crc_clr_o !== CLR_EXP ||
            crc_en_o !== 1'b0 || crc_data_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got w=%h v=%b b=%b d=%b m=%b o=%b clr=%b en=%b dat=%b, want all 0, clr=%b",
                     word_o, word_valid_o, busy_o, done_o, crc_match_o, overrun_o,
                     crc_clr_o, crc_en_o, crc_data_o, CLR_EXP);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_burst();
        word_ready_i = 1'b1;
        do_start(16'd2, "burst");
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_word(8'hA5, 1'b1);
        send_word(8'h3C, 1'b1);
`ifdef ADBG_BURST_RX_CRC_EN
        send_crc(crc_words(8'hA5, 8'h3C));
`endif
        wait_done(1'b1, "burst");
        n_cmp++;
        if (en_cnt != 2 * EN_PER_WORD) begin
            n_err++;
            $display("FAIL burst_crc_en_count: got %0d, want %0d", en_cnt, 2 * EN_PER_WORD);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL burst_words_left: got %0d outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_bad_crc();
        logic exp_m;
        word_ready_i = 1'b1;
        do_start(16'd2, "badcrc");
        send_bit(1'b1);
        send_word(8'h0F, 1'b1);
        send_word(8'hF0, 1'b1);
`ifdef ADBG_BURST_RX_CRC_EN
        send_crc(crc_words(8'h0F, 8'hF0) ^ 32'h0000_2000);
        exp_m = 1'b0;
`else
        exp_m = 1'b1;
`endif
        wait_done(exp_m, "badcrc");
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL badcrc_words_left: got %0d outstanding, want 0", exp_q.size());
        end
    endtask

    task automatic test_zero_count();
        word_ready_i = 1'b1;
        do_start(16'd0, "zero");
        send_bit(1'b1);
`ifdef ADBG_BURST_RX_CRC_EN
        send_crc(32'hFFFF_FFFF);
`endif
        wait_done(1'b1, "zero");
        n_cmp++;
        if (vld_cycles != 0 || en_cnt != 0) begin
            n_err++;
            $display("FAIL zero_activity: got valid_cycles=%0d crc_en=%0d, want 0 0", vld_cycles, en_cnt);
        end
    endtask

    task automatic test_overrun();
        word_ready_i = 1'b0;
        do_start(16'd2, "ovr");
        send_bit(1'b1);
        send_word(8'h11, 1'b0);
        n_cmp++;
        if (overrun_o !== 1'b0 || word_valid_o !== 1'b1 || word_o !== 8'h11) begin
            n_err++;
            $display("FAIL ovr_first: got ovr=%b vld=%b w=%h, want 0 1 11", overrun_o, word_valid_o, word_o);
        end
        send_word(8'h22, 1'b0);
        n_cmp++;
        if (overrun_o !== 1'b1 || word_valid_o !== 1'b1 || word_o !== 8'h22) begin
            n_err++;
            $display("FAIL ovr_second: got ovr=%b vld=%b w=%h, want 1 1 22", overrun_o, word_valid_o, word_o);
        end
`ifdef ADBG_BURST_RX_CRC_EN
        send_crc(crc_words(8'h11, 8'h22));
`endif
        wait_done(1'b1, "ovr");
        exp_q.push_back(8'h22);
        word_ready_i = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (exp_q.size() != 0 || word_valid_o !== 1'b0 || overrun_o !== 1'b1) begin
            n_err++;
            $display("FAIL ovr_drain: got left=%0d vld=%b ovr=%b, want 0 0 1", exp_q.size(), word_valid_o, overrun_o);
        end
    endtask

    task automatic test_restart();
        word_ready_i = 1'b1;
        do_start(16'd2, "abort");
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        do_start(16'd2, "restart");
        send_bit(1'b1);
        send_word(8'h5A, 1'b1);
        send_word(8'hC3, 1'b1);
`ifdef ADBG_BURST_RX_CRC_EN
        send_crc(crc_words(8'h5A, 8'hC3));
`endif
        wait_done(1'b1, "restart");
        n_cmp++;
        if (en_cnt != 2 * EN_PER_WORD || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL restart_tail: got crc_en=%0d left=%0d, want %0d 0", en_cnt, exp_q.size(), 2 * EN_PER_WORD);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] c;
        word_ready_i = 1'b1;
        do_start(16'd2, "rstmid");
        send_bit(1'b1);
        send_word(8'h66, 1'b1);
`ifdef ADBG_BURST_RX_CRC_EN
        send_word(8'h99, 1'b1);
        c = crc_words(8'h66, 8'h99);
        for (int i = 0; i < 10; i++) send_bit(c[i]);
`else
        c = '0;
        for (int i = 0; i < 3; i++) send_bit(1'b1);
`endif
        bit_valid_i = 1'b1;
        tdi_i       = 1'b1;
        rst         = 1'b1;
        #1;
        n_cmp++;
        if (word_o !== '0 || word_valid_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            crc_match_o !== 1'b0 || overrun_o !== 1'b0 || crc_clr_o !== CLR_EXP ||
            crc_en_o !== 1'b0 || crc_data_o !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_outputs: got w=%h v=%b b=%b d=%b m=%b o=%b clr=%b en=%b dat=%b, want all 0, clr=%b",
                     word_o, word_valid_o, busy_o, done_o, crc_match_o, overrun_o,
                     crc_clr_o, crc_en_o, crc_data_o, CLR_EXP);
        end
        bit_valid_i = 1'b0;
        tdi_i       = 1'b0;
        tick(); tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        tick(); tick();
        n_cmp++;
        if (done_cnt != 0 || busy_o !== 1'b0 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_after: got done_pulses=%0d busy=%b left=%0d, want 0 0 0",
                     done_cnt, busy_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_bad_crc();
        test_zero_count();
        test_overrun();
        test_restart();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion by 200000, want finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/adbg_burst_rx.md
ADBG_BURST_RX -- requirements
Module: adbg_burst_rx

Interface
REQ-001 Parameter DW, default 32, meaning data word width in bits (legal 8, 16, 32).
REQ-002 Parameter CW, default 16, meaning burst word-count width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start_i  input  1  one-cycle pulse; arms a new burst receive.
REQ-006 word_count_i  input  CW  number of words in burst; sampled on start_i.
REQ-007 bit_valid_i  input  1  tdi_i carries a valid serial bit this cycle (shift-DR qualified).
REQ-008 tdi_i  input  1  serial data, LSB first.
REQ-009 word_o  output  DW  deserialized word.
REQ-010 word_valid_o  output  1  word_o valid; held until accepted.
REQ-011 word_ready_i  input  1  downstream accepts word_o when high with word_valid_o.
REQ-012 crc_clr_o  output  1  clear pulse to the sibling CRC32 engine.
REQ-013 crc_en_o  output  1  CRC engine advance strobe.
REQ-014 crc_data_o  output  1  bit fed to CRC engine.
REQ-015 crc_i  input  32  running CRC value from the CRC engine.
REQ-016 busy_o  output  1  burst in progress.
REQ-017 done_o  output  1  one-cycle pulse at end of burst.
REQ-018 crc_match_o  output  1  received CRC equals computed CRC; valid from done_o until next start_i.
REQ-019 overrun_o  output  1  sticky: a word completed while previous word unaccepted.

Function
REQ-020 FSM states IDLE, WAIT_START, DATA, CRC_RX, CHECK; start_i from any state -> WAIT_START (abort and restart).
REQ-021 start_i: crc_clr_o high same cycle; load word counter, clear bit counter, overrun_o, crc_match_o, word_valid_o.
REQ-022 WAIT_START: bit_valid_i with tdi_i=1 -> DATA (start bit, not fed to CRC); tdi_i=0 bits ignored.
REQ-023 DATA: each valid bit combinationally drives crc_en_o=1, crc_data_o=tdi_i; bit shifted into word register from MSB side so first bit lands in bit 0.
REQ-024 DATA: on DW-th bit, word_o/word_valid_o update next cycle; word counter decrements; last word -> CRC_RX.
REQ-025 word_count_i=0: WAIT_START start bit goes directly to CRC_RX.
REQ-026 word_valid_o clears the cycle after word_ready_i high; word completing while word_valid_o still high sets overrun_o and overwrites word_o.
REQ-027 CRC_RX: 32 valid bits shifted LSB-first into rx_crc; crc_en_o held 0; after 32nd bit -> CHECK.
REQ-028 CHECK: single cycle; crc_match_o <= (rx_crc == crc_i); done_o pulse; -> IDLE.
REQ-029 bit_valid_i low: no state, counter or CRC change in any state.
REQ-030 busy_o high in WAIT_START, DATA, CRC_RX, CHECK.

Reset
REQ-031 rst: state IDLE; word_o=0, word_valid_o=0, busy_o=0, done_o=0, crc_match_o=0, overrun_o=0, crc_clr_o=1 while rst asserted, crc_en_o=0, crc_data_o=0.
REQ-032 rst mid-burst discards partial word and counters; no done_o pulse.

Configuration
REQ-033 Macro ADBG_BURST_RX_CRC_EN defined: CRC_RX/CHECK behaviour as above.
REQ-034 Macro absent: DATA last word -> CHECK directly, no CRC bits consumed, crc_match_o=1 at done_o, crc_clr_o/crc_en_o/crc_data_o tied 0.

Structure
REQ-035 adbg_pkg holds state enum, CRC width (32) and CRC init constant 32'hFFFFFFFF.
REQ-036 No sub-module; CRC engine remains a separate sibling instance connected via crc_* ports.

Verification
REQ-037 DW=8, count=2, start bit then bytes 0xA5,0x3C, ready=1 -> word_o 0xA5 then 0x3C, 16 crc_en_o pulses, model CRC sent -> crc_match_o=1, done_o one pulse.
REQ-038 Same burst, one received CRC bit flipped -> crc_match_o=0.
REQ-039 count=0, received CRC 0xFFFFFFFF -> crc_match_o=1, no word_valid_o.
REQ-040 ready held 0 across two words -> overrun_o=1, word_o=second word.
REQ-041 start_i mid-DATA after 3 bits -> crc_clr_o pulse, new burst receives correct words.
REQ-042 rst asserted mid-CRC_RX -> all outputs reset values, no done_o.
